seg7_scan_mux: RTL and testbench

//   Time-multiplexed scan driver for a DIGITS-wide common-anode 7-segment display.

---
 rtl/seg7_scan_mux.sv | 96 +++++++++
 tb/tb_seg7_scan_mux.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan driver for a common-anode 7-segment display.
// Double-buffered display word, anti-ghost blanking, select delayed to match decoder latency.
module seg7_scan_mux #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned SEG_LATENCY  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   iv_value,
  input  logic [DIGITS-1:0]     iv_blank_mask,
  output logic [3:0]            ov_nibble,
  output logic [DIGITS-1:0]     ov_digit_sel,
  output logic                  o_frame
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  pending_q, pending_d;
  logic [VAL_W-1:0]  active_q, active_d;
  logic [3:0]        nibble_q, nibble_d;
  logic              frame_q, frame_d;
  logic [DIGITS-1:0] raw_sel_d;
  // Stage 0 holds the registered raw select; stages 1..SEG_LATENCY track the decoder.
  logic [DIGITS-1:0] sel_pipe_q [SEG_LATENCY+1];

  logic slot_end_c;
  logic boundary_c;

  always_comb begin
    presc_d    = presc_q;
    idx_d      = idx_q;
    pending_d  = pending_q;
    active_d   = active_q;
    nibble_d   = active_q[{idx_q, 2'b00} +: 4];
    raw_sel_d  = '1;
    slot_end_c = (presc_q == PRE_W'(PRESCALE - 1));
    boundary_c = slot_end_c && (idx_q == IDX_W'(DIGITS - 1));
    frame_d    = boundary_c;

    if (slot_end_c) begin
      presc_d = '0;
      idx_d   = boundary_c ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end

    if (i_load) begin
      pending_d = iv_value;
    end
    // A load in the boundary cycle bypasses pending so it shows in the coming frame.
    if (boundary_c) begin
      active_d = i_load ? iv_value : pending_q;
    end

    if ((presc_q >= PRE_W'(BLANK_CYCLES)) && !iv_blank_mask[idx_q]) begin
      raw_sel_d = ~(DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      nibble_q  <= '0;
      frame_q   <= 1'b0;
      for (int i = 0; i <= int'(SEG_LATENCY); i++) begin
        sel_pipe_q[i] <= '1;
      end
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      active_q      <= active_d;
      nibble_q      <= nibble_d;
      frame_q       <= frame_d;
      sel_pipe_q[0] <= raw_sel_d;
      for (int i = 1; i <= int'(SEG_LATENCY); i++) begin
        sel_pipe_q[i] <= sel_pipe_q[i-1];
      end
    end
  end

  assign ov_nibble    = nibble_q;
  assign ov_digit_sel = sel_pipe_q[SEG_LATENCY];
  assign o_frame      = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux against a frame/slot arithmetic reference model.
module tb_seg7_scan_mux;

  localparam int unsigned D  = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned BL = 1;
  localparam int unsigned L  = 1;
  localparam int unsigned W  = 4 * D;
  localparam int unsigned FRAME = D * P;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_load;
  logic [W-1:0]  iv_value;
  logic [D-1:0]  iv_blank_mask;
  logic [3:0]    ov_nibble;
  logic [D-1:0]  ov_digit_sel;
  logic          o_frame;

  seg7_scan_mux #(
    .DIGITS(D), .PRESCALE(P), .BLANK_CYCLES(BL), .SEG_LATENCY(L)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_load(i_load), .iv_value(iv_value),
    .iv_blank_mask(iv_blank_mask), .ov_nibble(ov_nibble),
    .ov_digit_sel(ov_digit_sel), .o_frame(o_frame)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference state: edges since reset release, buffers, and decoder-latency queue.
  int           n;
  logic [W-1:0] mdl_pending, mdl_active;
  logic [D-1:0] sel_hist[$];
  logic [3:0]   exp_nibble;
  logic [D-1:0] exp_sel;
  logic         exp_frame;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got=%h expected=%h", tag, n, got, exp);
    end
  endtask

  task automatic model_reset();
    n           = 0;
    mdl_pending = '0;
    mdl_active  = '0;
    sel_hist    = {};
    for (int i = 0; i < int'(L); i++) sel_hist.push_back('1);
    exp_nibble  = '0;
    exp_sel     = '1;
    exp_frame   = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic [W-1:0] val, input logic [D-1:0] msk);
    int slot_pos, digit;
    logic [D-1:0] raw;
    slot_pos   = n % P;
    digit      = (n / P) % D;
    exp_nibble = 4'((mdl_active >> (4 * digit)) & W'(4'hF));
    raw = '1;
    if (slot_pos >= int'(BL) && !msk[digit]) raw[digit] = 1'b0;
    sel_hist.push_back(raw);
    exp_sel   = sel_hist.pop_front();
    exp_frame = ((n % FRAME) == FRAME - 1);
    if (exp_frame) mdl_active = ld ? val : mdl_pending;
    if (ld) mdl_pending = val;
    n++;
  endtask

  task automatic compare_all();
    check("nibble", 32'(ov_nibble), 32'(exp_nibble));
    check("digit_sel", 32'(ov_digit_sel), 32'(exp_sel));
    check("frame", 32'(o_frame), 32'(exp_frame));
    check("onehot", 32'($countones(~ov_digit_sel) <= 1), 32'd1);
  endtask

  task automatic run_cycle(input logic ld, input logic [W-1:0] val, input logic [D-1:0] msk);
    i_load        = ld;
    iv_value      = val;
    iv_blank_mask = msk;
    model_step(ld, val, msk);
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic run_random(input int cycles, input int load_pct, input logic rand_mask);
    for (int i = 0; i < cycles; i++) begin
      logic [D-1:0] msk;
      msk = rand_mask ? D'($urandom) : '0;
      run_cycle(($urandom_range(99) < load_pct), W'($urandom), msk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"}, 32'(ov_digit_sel), 32'(D'('1)));
    check({tag, "_nibble"}, 32'(ov_nibble), 32'd0);
    check({tag, "_frame"}, 32'(o_frame), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_frame;
    i_rst_n       = 1'b0;
    i_load        = 1'b0;
    iv_value      = '0;
    iv_blank_mask = '0;
    model_reset();
    repeat (5) begin
      @(negedge i_clk);
      check_reset_values("rst_hold");
    end
    i_rst_n = 1'b1;
    compare_all();

    // First frame pulse must appear exactly one frame after release.
    first_frame = -1;
    for (int i = 0; i < int'(FRAME) + 2; i++) begin
      run_cycle(1'b0, '0, '0);
      if (o_frame && first_frame < 0) first_frame = n;
    end
    check("first_frame_edge", 32'(first_frame), 32'(FRAME));

    // Load a fixed word mid-frame, then run two full frames.
    run_cycle(1'b1, 16'h1234, '0);
    for (int i = 0; i < 2 * int'(FRAME) + 4; i++) run_cycle(1'b0, '0, '0);

    // Mid-frame load: old word must persist until the next boundary.
    while ((n % FRAME) != 5) run_cycle(1'b0, '0, '0);
    run_cycle(1'b1, 16'hABCD, '0);
    for (int i = 0; i < int'(FRAME) + 4; i++) run_cycle(1'b0, '0, '0);

    // Load exactly in the boundary cycle: takes effect in the coming frame.
    while ((n % FRAME) != FRAME - 1) run_cycle(1'b0, '0, '0);
    run_cycle(1'b1, 16'h5E7F, '0);
    for (int i = 0; i < int'(FRAME) + 2; i++) run_cycle(1'b0, '0, '0);

    // Digit 2 blanked while other digits scan normally.
    for (int i = 0; i < 3 * int'(FRAME); i++)
      run_cycle(($urandom_range(9) == 0), W'($urandom), 4'b0100);

    run_random(300, 15, 1'b1);

    // Async reset mid-slot of digit 2.
    while ((n % FRAME) != 9) run_cycle(1'b0, '0, '0);
    #2 i_rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_values("rst_again");
    i_rst_n = 1'b1;
    for (int i = 0; i < int'(FRAME); i++) run_cycle(1'b0, '0, '0);
    run_random(200, 20, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
